// File: rtl/board_store_if.sv
// rtl/board_store_if.sv - move/undo request and board readout bundle for board_store
interface board_store_if #(
  parameter int ROW_BITS   = 3,
  parameter int COL_BITS   = 3,
  parameter int PIECE_W    = 4,
  parameter int HIST_DEPTH = 8
);
  localparam int A       = ROW_BITS + COL_BITS;
  localparam int SQUARES = 2 ** A;
  localparam int CW      = $clog2(HIST_DEPTH + 1);

  logic                       MOVE_VALID;
  logic                       MOVE_READY;
  logic [A-1:0]               MOVE_FROM;
  logic [A-1:0]               MOVE_TO;
  logic [PIECE_W-1:0]         MOVE_PIECE;
  logic                       UNDO_VALID;
  logic                       UNDO_READY;
  logic [SQUARES*PIECE_W-1:0] BOARD_OUT;
  logic                       INIT_DONE;
  logic                       DONE;
  logic                       ERR;
  logic [PIECE_W-1:0]         CAPTURED;
  logic [CW-1:0]              HIST_COUNT;

  modport master (
    output MOVE_VALID, MOVE_FROM, MOVE_TO, MOVE_PIECE, UNDO_VALID,
    input  MOVE_READY, UNDO_READY, BOARD_OUT, INIT_DONE, DONE, ERR, CAPTURED, HIST_COUNT
  );

  modport slave (
    input  MOVE_VALID, MOVE_FROM, MOVE_TO, MOVE_PIECE, UNDO_VALID,
    output MOVE_READY, UNDO_READY, BOARD_OUT, INIT_DONE, DONE, ERR, CAPTURED, HIST_COUNT
  );
endinterface

// File: rtl/board_store.sv
// rtl/board_store.sv - board register with start-image load, two-square moves and undo history
module board_store #(
  parameter int ROW_BITS   = 3,
  parameter int COL_BITS   = 3,
  parameter int PIECE_W    = 4,
  parameter int HIST_DEPTH = 8,
  parameter logic [(2**(ROW_BITS+COL_BITS))*PIECE_W-1:0] INIT_IMAGE =
    256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC
) (
  input  logic         CLK,
  input  logic         RESET,
  board_store_if.slave bus
);
  localparam int A       = ROW_BITS + COL_BITS;
  localparam int SQUARES = 2 ** A;
  localparam int CW      = $clog2(HIST_DEPTH + 1);
  localparam int PTR_W   = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  typedef enum logic [2:0] {INIT, IDLE, MV_TO, MV_FROM, UN_TO, UN_FROM} state_t;

  typedef struct packed {
    logic [A-1:0]       from;
    logic [A-1:0]       to;
    logic [PIECE_W-1:0] old_from;
    logic [PIECE_W-1:0] old_to;
  } hist_t;

  state_t                     state_q, state_d;
  logic [A-1:0]               init_cnt_q, init_cnt_d;
  logic [SQUARES*PIECE_W-1:0] board_q, board_d;
  hist_t                      hist_q [HIST_DEPTH];
  hist_t                      hist_d [HIST_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              hist_count_q, hist_count_d;
  logic [A-1:0]               op_from_q, op_from_d;
  logic [A-1:0]               op_to_q, op_to_d;
  logic [PIECE_W-1:0]         op_to_val_q, op_to_val_d;
  logic [PIECE_W-1:0]         op_from_val_q, op_from_val_d;
  logic [PIECE_W-1:0]         op_cap_q, op_cap_d;
  logic [PIECE_W-1:0]         captured_q, captured_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
  logic                       init_done_q, init_done_d;

  logic                       wr_en;
  logic [A-1:0]               wr_addr;
  logic [PIECE_W-1:0]         wr_data;
  logic [PTR_W-1:0]           ptr_inc, ptr_dec;
  hist_t                      hist_top;

  assign ptr_inc  = (wr_ptr_q == PTR_W'(HIST_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
  assign ptr_dec  = (wr_ptr_q == '0) ? PTR_W'(HIST_DEPTH - 1) : wr_ptr_q - PTR_W'(1);
  assign hist_top = hist_q[ptr_dec];

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    hist_d        = hist_q;
    wr_ptr_d      = wr_ptr_q;
    hist_count_d  = hist_count_q;
    op_from_d     = op_from_q;
    op_to_d       = op_to_q;
    op_to_val_d   = op_to_val_q;
    op_from_val_d = op_from_val_q;
    op_cap_d      = op_cap_q;
    captured_d    = captured_q;
    init_done_d   = init_done_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;

    case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_addr    = init_cnt_q;
        wr_data    = INIT_IMAGE[init_cnt_q*PIECE_W +: PIECE_W];
        init_cnt_d = init_cnt_q + A'(1);
        if (init_cnt_q == A'(SQUARES - 1)) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: begin
        // Undo has priority; MOVE_READY is already low whenever UNDO_VALID is high.
        if (bus.UNDO_VALID) begin
          if (hist_count_q == '0) begin
            err_d = 1'b1;
          end else begin
            op_from_d     = hist_top.from;
            op_to_d       = hist_top.to;
            op_to_val_d   = hist_top.old_to;
            op_from_val_d = hist_top.old_from;
            wr_ptr_d      = ptr_dec;
            hist_count_d  = hist_count_q - CW'(1);
            state_d       = UN_TO;
          end
        end else if (bus.MOVE_VALID) begin
          if (bus.MOVE_FROM == bus.MOVE_TO) begin
            err_d = 1'b1;
          end else begin
            op_from_d        = bus.MOVE_FROM;
            op_to_d          = bus.MOVE_TO;
            op_to_val_d      = bus.MOVE_PIECE;
            op_from_val_d    = '0;
            op_cap_d         = board_q[bus.MOVE_TO*PIECE_W +: PIECE_W];
            hist_d[wr_ptr_q] = '{from:     bus.MOVE_FROM,
                                 to:       bus.MOVE_TO,
                                 old_from: board_q[bus.MOVE_FROM*PIECE_W +: PIECE_W],
                                 old_to:   board_q[bus.MOVE_TO*PIECE_W +: PIECE_W]};
            wr_ptr_d         = ptr_inc;
            if (hist_count_q != CW'(HIST_DEPTH)) hist_count_d = hist_count_q + CW'(1);
            state_d          = MV_TO;
          end
        end
      end
      MV_TO, UN_TO: begin
        wr_en   = 1'b1;
        wr_addr = op_to_q;
        wr_data = op_to_val_q;
        state_d = (state_q == MV_TO) ? MV_FROM : UN_FROM;
      end
      MV_FROM, UN_FROM: begin
        wr_en   = 1'b1;
        wr_addr = op_from_q;
        wr_data = op_from_val_q;
        done_d  = 1'b1;
        if (state_q == MV_FROM) captured_d = op_cap_q;
        state_d = IDLE;
      end
      default: state_d = INIT;
    endcase

    board_d = board_q;
    if (wr_en) board_d[wr_addr*PIECE_W +: PIECE_W] = wr_data;
  end

  always_ff @(posedge CLK) begin
    // Board, history slots and operands need no reset: INIT rewrites every square
    // and a cleared count makes stale history slots unreachable.
    board_q       <= board_d;
    hist_q        <= hist_d;
    op_from_q     <= op_from_d;
    op_to_q       <= op_to_d;
    op_to_val_q   <= op_to_val_d;
    op_from_val_q <= op_from_val_d;
    op_cap_q      <= op_cap_d;
    if (RESET) begin
      state_q      <= INIT;
      init_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      hist_count_q <= '0;
      captured_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      hist_count_q <= hist_count_d;
      captured_q   <= captured_d;
      done_q       <= done_d;
      err_q        <= err_d;
      init_done_q  <= init_done_d;
    end
  end

  assign bus.MOVE_READY = (state_q == IDLE) & ~bus.UNDO_VALID;
  assign bus.UNDO_READY = (state_q == IDLE);
  assign bus.BOARD_OUT  = board_q;
  assign bus.INIT_DONE  = init_done_q;
  assign bus.DONE       = done_q;
  assign bus.ERR        = err_q;
  assign bus.CAPTURED   = captured_q;
  assign bus.HIST_COUNT = hist_count_q;
endmodule

// File: tb/tb_board_store.sv
// tb/tb_board_store.sv - directed self-checking bench for board_store
module tb_board_store;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_store_if #(.ROW_BITS(3), .COL_BITS(3), .PIECE_W(4), .HIST_DEPTH(8)) bif();

  board_store #(.ROW_BITS(3), .COL_BITS(3), .PIECE_W(4), .HIST_DEPTH(8)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bif.slave)
  );

  localparam logic [255:0] START =
    256'h42365324_11111111_00000000_00000000_00000000_00000000_99999999_CABEDBAC;

  int tests = 0;
  int fails = 0;
  logic [255:0] exp_board;
  logic [255:0] after_m1;
  logic [255:0] snaps [9];
  int res;
  int n;
  bit seen_done;
  int mv_from [9] = '{52, 51, 12, 11, 62,  6, 48,  1, 53};
  int mv_to   [9] = '{36, 35, 28, 27, 45, 21, 40, 18, 37};

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sq(input logic [255:0] b, input int i);
    return b[i*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // res: 1 = DONE seen, 2 = ERR at accept edge, 0 = never ready or no completion
  task automatic request(input bit undo, input int from, input int to,
                         input logic [3:0] piece, output int r);
    bit rdy;
    r = 0;
    rdy = 1'b0;
    bif.MOVE_FROM  = 6'(from);
    bif.MOVE_TO    = 6'(to);
    bif.MOVE_PIECE = piece;
    bif.UNDO_VALID = undo;
    bif.MOVE_VALID = !undo;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (undo ? bif.UNDO_READY : bif.MOVE_READY) begin
        rdy = 1'b1;
        break;
      end
      tick();
    end
    if (rdy) begin
      tick();
      bif.MOVE_VALID = 1'b0;
      bif.UNDO_VALID = 1'b0;
      if (bif.ERR) begin
        r = 2;
      end else begin
        for (int i = 0; i < 4; i++) begin
          tick();
          if (bif.DONE) begin
            r = 1;
            break;
          end
        end
      end
    end
    bif.MOVE_VALID = 1'b0;
    bif.UNDO_VALID = 1'b0;
  endtask

  task automatic reset_and_load(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (!bif.MOVE_READY && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_init_cycles"}, n, 64);
    check({tag, "_init_done"}, bif.INIT_DONE, 1);
    check({tag, "_board"}, bif.BOARD_OUT, START);
  endtask

  initial begin
    bif.MOVE_VALID = 1'b0;
    bif.UNDO_VALID = 1'b0;
    bif.MOVE_FROM  = '0;
    bif.MOVE_TO    = '0;
    bif.MOVE_PIECE = '0;

    // Reset state and start-image load
    rst = 1'b1;
    tick();
    check("rst_move_ready", bif.MOVE_READY, 0);
    check("rst_undo_ready", bif.UNDO_READY, 0);
    check("rst_init_done", bif.INIT_DONE, 0);
    check("rst_hist", bif.HIST_COUNT, 0);
    check("rst_done", bif.DONE, 0);
    check("rst_err", bif.ERR, 0);
    check("rst_captured", bif.CAPTURED, 0);
    rst = 1'b0;
    n = 0;
    while (!bif.MOVE_READY && n < 200) begin
      tick();
      n++;
      if (n == 63) check("init_done_early", bif.INIT_DONE, 0);
    end
    check("init_cycles", n, 64);
    check("init_done", bif.INIT_DONE, 1);
    check("init_board", bif.BOARD_OUT, START);
    check("init_sq52", sq(bif.BOARD_OUT, 52), 4'h1);
    check("init_sq0", sq(bif.BOARD_OUT, 0), 4'hC);
    check("init_sq36", sq(bif.BOARD_OUT, 36), 4'h0);
    exp_board = START;

    // Move 52->36 with cycle-exact checks
    bif.MOVE_FROM = 6'd52; bif.MOVE_TO = 6'd36; bif.MOVE_PIECE = 4'h1;
    bif.MOVE_VALID = 1'b1;
    tick();
    bif.MOVE_VALID = 1'b0;
    check("m1_k_hist", bif.HIST_COUNT, 1);
    check("m1_k_ready", bif.MOVE_READY, 0);
    check("m1_k_done", bif.DONE, 0);
    tick();
    check("m1_k1_sq36", sq(bif.BOARD_OUT, 36), 4'h1);
    check("m1_k1_sq52", sq(bif.BOARD_OUT, 52), 4'h1);
    check("m1_k1_done", bif.DONE, 0);
    tick();
    check("m1_k2_sq36", sq(bif.BOARD_OUT, 36), 4'h1);
    check("m1_k2_sq52", sq(bif.BOARD_OUT, 52), 4'h0);
    check("m1_k2_done", bif.DONE, 1);
    check("m1_k2_captured", bif.CAPTURED, 0);
    check("m1_k2_ready", bif.MOVE_READY, 1);
    tick();
    check("m1_done_pulse", bif.DONE, 0);
    exp_board[36*4 +: 4] = 4'h1;
    exp_board[52*4 +: 4] = 4'h0;
    after_m1 = exp_board;

    // Capture of the black pawn on 12, then undo
    request(1'b0, 36, 12, 4'h1, res);
    check("cap_res", res, 1);
    check("cap_captured", bif.CAPTURED, 4'h9);
    check("cap_hist", bif.HIST_COUNT, 2);
    check("cap_sq12", sq(bif.BOARD_OUT, 12), 4'h1);
    check("cap_sq36", sq(bif.BOARD_OUT, 36), 4'h0);
    request(1'b1, 0, 0, 4'h0, res);
    check("cap_undo_res", res, 1);
    check("cap_undo_board", bif.BOARD_OUT, after_m1);
    check("cap_undo_hist", bif.HIST_COUNT, 1);
    check("cap_undo_captured", bif.CAPTURED, 4'h9);

    // Nine moves from a fresh start, then ten undos
    reset_and_load("reload1");
    exp_board = START;
    for (int i = 0; i < 9; i++) begin
      logic [3:0] p;
      p = (i == 6) ? 4'h5 : sq(exp_board, mv_from[i]);
      snaps[i] = exp_board;
      request(1'b0, mv_from[i], mv_to[i], p, res);
      check($sformatf("hist_mv%0d_res", i), res, 1);
      exp_board[mv_to[i]*4 +: 4]   = p;
      exp_board[mv_from[i]*4 +: 4] = 4'h0;
      check($sformatf("hist_mv%0d_board", i), bif.BOARD_OUT, exp_board);
      check($sformatf("hist_mv%0d_count", i), bif.HIST_COUNT, (i < 8) ? i + 1 : 8);
      if (i == 0) after_m1 = exp_board;
    end
    for (int i = 0; i < 10; i++) begin
      request(1'b1, 0, 0, 4'h0, res);
      check($sformatf("undo%0d_res", i), res, (i < 8) ? 1 : 2);
      check($sformatf("undo%0d_count", i), bif.HIST_COUNT, (i < 8) ? 7 - i : 0);
      if (i < 8) check($sformatf("undo%0d_board", i), bif.BOARD_OUT, snaps[8 - i]);
    end
    check("undo_final_board", bif.BOARD_OUT, after_m1);
    exp_board = after_m1;

    // from == to is rejected without touching board or history
    request(1'b0, 51, 35, 4'h1, res);
    check("pre_same_res", res, 1);
    exp_board[35*4 +: 4] = 4'h1;
    exp_board[51*4 +: 4] = 4'h0;
    request(1'b0, 20, 20, 4'h3, res);
    check("same_res", res, 2);
    check("same_board", bif.BOARD_OUT, exp_board);
    check("same_hist", bif.HIST_COUNT, 1);
    tick();
    check("same_err_pulse", bif.ERR, 0);
    check("same_ready", bif.MOVE_READY, 1);

    // Simultaneous move and undo: undo wins, held move follows
    bif.MOVE_FROM = 6'd12; bif.MOVE_TO = 6'd28; bif.MOVE_PIECE = 4'h9;
    bif.MOVE_VALID = 1'b1;
    bif.UNDO_VALID = 1'b1;
    #1;
    check("sim_move_ready", bif.MOVE_READY, 0);
    check("sim_undo_ready", bif.UNDO_READY, 1);
    tick();
    bif.UNDO_VALID = 1'b0;
    check("sim_undo_hist", bif.HIST_COUNT, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.DONE) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("sim_undo_done", seen_done, 1);
    check("sim_undo_board", bif.BOARD_OUT, after_m1);
    check("sim_move_ready_after", bif.MOVE_READY, 1);
    tick();
    bif.MOVE_VALID = 1'b0;
    check("sim_move_accept_hist", bif.HIST_COUNT, 1);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bif.DONE) begin
        seen_done = 1'b1;
        break;
      end
    end
    check("sim_move_done", seen_done, 1);
    check("sim_move_sq28", sq(bif.BOARD_OUT, 28), 4'h9);
    check("sim_move_sq12", sq(bif.BOARD_OUT, 12), 4'h0);
    check("sim_move_captured", bif.CAPTURED, 4'h0);

    // Reset during a move discards it and reloads the start image
    bif.MOVE_FROM = 6'd28; bif.MOVE_TO = 6'd20; bif.MOVE_PIECE = 4'h9;
    bif.MOVE_VALID = 1'b1;
    tick();
    bif.MOVE_VALID = 1'b0;
    check("rmv_accept_hist", bif.HIST_COUNT, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmv_done", bif.DONE, 0);
    check("rmv_hist", bif.HIST_COUNT, 0);
    check("rmv_ready", bif.MOVE_READY, 0);
    check("rmv_init_done", bif.INIT_DONE, 0);
    n = 0;
    seen_done = 1'b0;
    while (!bif.MOVE_READY && n < 200) begin
      tick();
      n++;
      if (bif.DONE) seen_done = 1'b1;
    end
    check("rmv_init_cycles", n, 64);
    check("rmv_no_done", seen_done, 0);
    check("rmv_board", bif.BOARD_OUT, START);
    check("rmv_hist_after", bif.HIST_COUNT, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
